// File: rtl/ser_strobe_pkg.sv
// Purpose: shared state encoding and counter-width helper for the strobe transmitter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ser_strobe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ser_strobe_timer.sv
// Purpose: bit-period timer; div_cnt runs 0..DIV-1 while run is high and marks period start/end.
// Latency: strobe in the first cycle run is seen high, bit_end DIV-1 cycles later.
// Backpressure: none; free-running while run=1, held at 0 otherwise.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   run         transmitter is in a bit-emitting state
//   strobe      first cycle of a bit period (div_cnt==0)
//   bit_end     last cycle of a bit period (div_cnt==DIV-1)
module ser_strobe_timer
    import ser_strobe_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic strobe,
    output logic bit_end
);

    localparam int              DW       = cnt_w(DIV);
    localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!run || bit_end) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // With DIV=1 both pulses are high every cycle, which gives one bit per clock.
    assign strobe  = run && (div_cnt == '0);
    assign bit_end = run && (div_cnt == DIV_LAST);

endmodule

// File: rtl/ser_strobe_tx.sv
// Purpose: parallel-to-serial transmitter driving a ser_d/ser_e pair for an enabled-DFF capture chain.
// Latency: first strobe one cycle after the handshake; back in IDLE WIDTH*DIV+1 cycles after it.
// Backpressure: tx_ready (registered) is high only in IDLE; tx_valid is ignored while it is low.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   tx_valid, tx_data   producer word, taken when tx_valid && tx_ready
//   tx_ready            block can accept a word
//   ser_d, ser_e        serial bit (held per bit period) and one-cycle capture strobe
//   busy                a word is being transmitted
// Option: SER_STROBE_TX_PARITY_EN appends one even-parity bit period after the data bits.
module ser_strobe_tx
    import ser_strobe_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    output logic             ser_d,
    output logic             ser_e,
    output logic             busy
);

    localparam int            BW       = cnt_w(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic             tx_ready_q;
    logic             run;
    logic             strobe;
    logic             bit_end;
    logic             accept;
    logic             last_bit;
    logic             cur_bit;
    logic             ser_d_c;
`ifdef SER_STROBE_TX_PARITY_EN
    logic             par_q;
`endif

    assign run      = (state != ST_IDLE);
    assign accept   = tx_valid && tx_ready_q && (state == ST_IDLE);
    assign last_bit = (state == ST_SHIFT) && bit_end && (bit_cnt == BIT_LAST);
    // The bit on the wire is always at the output end of the shift register.
    assign cur_bit  = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];

    ser_strobe_timer #(
        .DIV (DIV)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .strobe  (strobe),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            tx_ready_q <= 1'b0;
        end else begin
            state      <= next_state;
            // Ready follows the state we are about to enter, so it is high in every IDLE
            // cycle, including the first one after reset and the gap between words.
            tx_ready_q <= (next_state == ST_IDLE);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
`ifdef SER_STROBE_TX_PARITY_EN
                    next_state = ST_PAR;
`else
                    next_state = ST_IDLE;
`endif
                end
            end
`ifdef SER_STROBE_TX_PARITY_EN
            ST_PAR: begin
                if (bit_end) begin
                    next_state = ST_IDLE;
                end
            end
`endif
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            shreg   <= tx_data;
            bit_cnt <= '0;
        end else if ((state == ST_SHIFT) && bit_end) begin
            shreg   <= (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                        : {1'b0, shreg[WIDTH-1:1]};
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        end
    end

`ifdef SER_STROBE_TX_PARITY_EN
    // Parity is taken from the word at the handshake, so later tx_data changes cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^tx_data;
        end
    end
`endif

    always_comb begin
        ser_d_c = 1'b0;
        case (state)
            ST_SHIFT: ser_d_c = cur_bit;
`ifdef SER_STROBE_TX_PARITY_EN
            ST_PAR:   ser_d_c = par_q;
`endif
            default:  ser_d_c = 1'b0;
        endcase
    end

    // Outputs are decoded from reset-cleared flops only, so an asynchronous reset
    // kills the strobe and data in the same instant, with no partial strobe.
    assign tx_ready = tx_ready_q;
    assign ser_d    = ser_d_c;
    assign ser_e    = strobe;
    assign busy     = run;

endmodule

// File: tb/tb_ser_strobe_tx.sv
// Purpose: self-checking bench for ser_strobe_tx across LSB-first, MSB-first and DIV=1 builds.
// Latency: checks every cycle of each word against hand-derived bit sequences.
// Backpressure: exercises held tx_valid while tx_ready is low and back-to-back words.
module tb_ser_strobe_tx;

`ifdef SER_STROBE_TX_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic [7:0] seq;   // seq[k] = k-th bit expected on the wire
        logic       par;   // even parity of data, hand-computed
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] v;
    logic [7:0] d [3];
    logic [2:0] rdy;
    logic [2:0] sd;
    logic [2:0] se;
    logic [2:0] bz;

    int n_chk;
    int n_fail;

    vec_t tv [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // u_a: LSB first, DIV=4; u_b: MSB first, DIV=4; u_c: LSB first, DIV=1.
    ser_strobe_tx #(.WIDTH(8), .DIV(4), .MSB_FIRST(0)) u_a (
        .clk(clk), .rst_n(rst_n), .tx_valid(v[0]), .tx_data(d[0]),
        .tx_ready(rdy[0]), .ser_d(sd[0]), .ser_e(se[0]), .busy(bz[0]));
    ser_strobe_tx #(.WIDTH(8), .DIV(4), .MSB_FIRST(1)) u_b (
        .clk(clk), .rst_n(rst_n), .tx_valid(v[1]), .tx_data(d[1]),
        .tx_ready(rdy[1]), .ser_d(sd[1]), .ser_e(se[1]), .busy(bz[1]));
    ser_strobe_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(0)) u_c (
        .clk(clk), .rst_n(rst_n), .tx_valid(v[2]), .tx_data(d[2]),
        .tx_ready(rdy[2]), .ser_d(sd[2]), .ser_e(se[2]), .busy(bz[2]));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input int sel);
        int budget;
        budget = 50;
        while (rdy[sel] !== 1'b1 && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) chk($sformatf("wait_ready_timeout_dut%0d", sel), 8'd0, 8'd1);
    endtask

    // Handshake at the next edge (cycle 0); returns at the cycle-1 sample point with
    // tx_valid dropped and tx_data scrambled.
    task automatic launch(input int sel, input logic [7:0] data);
        wait_rdy(sel);
        v[sel] = 1'b1;
        d[sel] = data;
        step();
        v[sel] = 1'b0;
        d[sel] = ~data;
    endtask

    // Called at cycle 1; checks every cycle of the word, returns at the first idle cycle.
    task automatic check_word(input int sel, input logic [7:0] seq, input logic par);
        int   div;
        int   n;
        int   k;
        logic eb;
        div = (sel == 2) ? 1 : 4;
        n   = NB * div;
        for (int c = 0; c < n; c++) begin
            k  = c / div;
            eb = (k < 8) ? seq[k] : par;
            chk($sformatf("ser_e_dut%0d_cyc%0d", sel, c + 1), {7'd0, se[sel]}, {7'd0, (c % div) == 0});
            chk($sformatf("ser_d_dut%0d_cyc%0d", sel, c + 1), {7'd0, sd[sel]}, {7'd0, eb});
            chk($sformatf("busy_dut%0d_cyc%0d", sel, c + 1), {7'd0, bz[sel]}, 8'd1);
            chk($sformatf("ready_dut%0d_cyc%0d", sel, c + 1), {7'd0, rdy[sel]}, 8'd0);
            step();
        end
        chk($sformatf("end_ready_dut%0d", sel), {7'd0, rdy[sel]}, 8'd1);
        chk($sformatf("end_busy_dut%0d", sel), {7'd0, bz[sel]}, 8'd0);
        chk($sformatf("end_ser_d_dut%0d", sel), {7'd0, sd[sel]}, 8'd0);
        chk($sformatf("end_ser_e_dut%0d", sel), {7'd0, se[sel]}, 8'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        tv[0] = '{sel: 0, data: 8'hA5, seq: 8'hA5, par: 1'b0};
        tv[1] = '{sel: 0, data: 8'h01, seq: 8'h01, par: 1'b1};
        tv[2] = '{sel: 0, data: 8'h2D, seq: 8'h2D, par: 1'b0};
        tv[3] = '{sel: 1, data: 8'h01, seq: 8'h80, par: 1'b1};
        tv[4] = '{sel: 1, data: 8'h2D, seq: 8'hB4, par: 1'b0};
        tv[5] = '{sel: 2, data: 8'hFF, seq: 8'hFF, par: 1'b0};
        tv[6] = '{sel: 2, data: 8'h6A, seq: 8'h6A, par: 1'b0};
        tv[7] = '{sel: 0, data: 8'h07, seq: 8'h07, par: 1'b1};

        // Reset hold with tx_valid asserted.
        rst_n = 1'b0;
        v     = 3'b111;
        for (int i = 0; i < 3; i++) begin
            d[i] = 8'h5A;
        end
        for (int i = 0; i < 3; i++) begin
            #4;
            chk($sformatf("rst_ready_%0d", i), {5'd0, rdy}, 8'd0);
            chk($sformatf("rst_outs_%0d", i), {5'd0, sd | se | bz}, 8'd0);
        end
        rst_n = 1'b1;
        step();
        chk("ready_after_release", {5'd0, rdy}, 8'h07);
        chk("busy_after_release", {5'd0, bz}, 8'd0);
        v = 3'b000;
        step();

        // Table-driven words.
        for (int i = 0; i < 8; i++) begin
            launch(tv[i].sel, tv[i].data);
            check_word(tv[i].sel, tv[i].seq, tv[i].par);
            step();
        end

        // Back-to-back MSB-first words with tx_valid held high throughout.
        wait_rdy(1);
        v[1] = 1'b1;
        d[1] = 8'h81;
        step();
        d[1] = 8'h3C;
        check_word(1, 8'h81, 1'b0);
        step();
        v[1] = 1'b0;
        d[1] = 8'h00;
        check_word(1, 8'h3C, 1'b0);
        step();

        // Reset mid-word: cycle 10 of 0xA5 sits in bit 2 (value 1).
        launch(0, 8'hA5);
        repeat (9) step();
        chk("midword_ser_d_before", {7'd0, sd[0]}, 8'd1);
        chk("midword_busy_before", {7'd0, bz[0]}, 8'd1);
        rst_n = 1'b0;
        #1;
        chk("midword_ser_e_reset", {7'd0, se[0]}, 8'd0);
        chk("midword_ser_d_reset", {7'd0, sd[0]}, 8'd0);
        chk("midword_busy_reset", {7'd0, bz[0]}, 8'd0);
        chk("midword_ready_reset", {7'd0, rdy[0]}, 8'd0);
        repeat (2) @(posedge clk);
        #3;
        chk("midword_ser_e_held", {7'd0, se[0]}, 8'd0);
        rst_n = 1'b1;
        step();
        chk("midword_ready_release", {7'd0, rdy[0]}, 8'd1);
        launch(0, 8'h0F);
        check_word(0, 8'h0F, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
